// File: rtl/ambiente_robo.sv
// Behavioural 8x8 grid-world environment for the debris-clearing robot controller.
// Optional statistics outputs (n_passos, n_colisoes) are built when AMBIENTE_ESTAT_EN is defined.
module ambiente_robo #(
    parameter logic [63:0] WALL_MAP       = 64'h0,
    parameter logic [63:0] DEBRIS_MAP     = 64'h0,
    parameter int          START_X        = 0,
    parameter int          START_Y        = 0,
    parameter int          START_DIR      = 0,
    parameter int          GOAL_X         = 7,
    parameter int          GOAL_Y         = 7,
    parameter int          COLLECT_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       avancar,
    input  logic       girar,
    input  logic       recolher_entulho,
    output logic       head,
    output logic       left,
    output logic       under,
    output logic       barrier,
    output logic [2:0] pos_x,
    output logic [2:0] pos_y,
    output logic [1:0] direcao,
    output logic       colisao,
    output logic       entulho_removido,
`ifdef AMBIENTE_ESTAT_EN
    output logic [15:0] n_passos,
    output logic [7:0]  n_colisoes,
`endif
    output logic       cmd_invalido
);

    localparam logic [3:0] LAST_CNT = 4'(COLLECT_CYCLES - 1);

    logic [63:0] debris;
    logic [3:0]  coleta_cnt;

    // 4-bit two's-complement step; any result with bit 3 set is outside 0..7
    function automatic logic [3:0] delta_x(input logic [1:0] d);
        case (d)
            2'd1:    delta_x = 4'b0001;
            2'd3:    delta_x = 4'b1111;
            default: delta_x = 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] delta_y(input logic [1:0] d);
        case (d)
            2'd0:    delta_y = 4'b0001;
            2'd2:    delta_y = 4'b1111;
            default: delta_y = 4'b0000;
        endcase
    endfunction

    logic [1:0] left_dir;
    logic [3:0] ahead_x, ahead_y, left_x, left_y;
    logic       ahead_in, left_in;
    logic [5:0] ahead_idx, left_idx;

    always_comb begin
        left_dir  = direcao + 2'd3;
        ahead_x   = {1'b0, pos_x} + delta_x(direcao);
        ahead_y   = {1'b0, pos_y} + delta_y(direcao);
        left_x    = {1'b0, pos_x} + delta_x(left_dir);
        left_y    = {1'b0, pos_y} + delta_y(left_dir);
        ahead_in  = ~ahead_x[3] & ~ahead_y[3];
        left_in   = ~left_x[3] & ~left_y[3];
        ahead_idx = {ahead_y[2:0], ahead_x[2:0]};
        left_idx  = {left_y[2:0], left_x[2:0]};
        head      = ~ahead_in | WALL_MAP[ahead_idx];
        barrier   = ahead_in & ~WALL_MAP[ahead_idx] & debris[ahead_idx];
        left      = ~left_in | WALL_MAP[left_idx];
        under     = (pos_x == 3'(GOAL_X)) && (pos_y == 3'(GOAL_Y));
    end

    logic multi_cmd, do_move, do_refuse;

    always_comb begin
        multi_cmd = (avancar & girar) | (avancar & recolher_entulho) | (girar & recolher_entulho);
        do_move   = avancar & ~girar & ~recolher_entulho & ~head & ~barrier;
        do_refuse = avancar & ~girar & ~recolher_entulho & (head | barrier);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pos_x            <= 3'(START_X);
            pos_y            <= 3'(START_Y);
            direcao          <= 2'(START_DIR);
            debris           <= DEBRIS_MAP & ~WALL_MAP;
            coleta_cnt       <= 4'd0;
            colisao          <= 1'b0;
            entulho_removido <= 1'b0;
            cmd_invalido     <= 1'b0;
        end else begin
            // pulses and the collection count drop unless the branch below keeps them
            colisao          <= do_refuse;
            entulho_removido <= 1'b0;
            cmd_invalido     <= multi_cmd;
            coleta_cnt       <= 4'd0;
            if (recolher_entulho) begin
                if (barrier) begin
                    if (coleta_cnt == LAST_CNT) begin
                        debris[ahead_idx] <= 1'b0;
                        entulho_removido  <= 1'b1;
                    end else begin
                        coleta_cnt <= coleta_cnt + 4'd1;
                    end
                end
            end else if (girar) begin
                direcao <= direcao + 2'd3;
            end else if (do_move) begin
                pos_x <= ahead_x[2:0];
                pos_y <= ahead_y[2:0];
            end
        end
    end

`ifdef AMBIENTE_ESTAT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            n_passos   <= 16'd0;
            n_colisoes <= 8'd0;
        end else begin
            if (do_move && n_passos != 16'hFFFF)
                n_passos <= n_passos + 16'd1;
            if (do_refuse && n_colisoes != 8'hFF)
                n_colisoes <= n_colisoes + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ambiente_robo.sv
// Directed bench for ambiente_robo: four environments share one command stream,
// each instance answers a different scenario (empty, wall, debris, start on goal).
module tb_ambiente_robo;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic avancar = 1'b0, girar = 1'b0, recolher_entulho = 1'b0;

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic       head[4], left[4], under[4], barrier[4];
    logic [2:0] pos_x[4], pos_y[4];
    logic [1:0] direcao[4];
    logic       colisao[4], entulho_removido[4], cmd_invalido[4];
`ifdef AMBIENTE_ESTAT_EN
    logic [15:0] n_passos[4];
    logic [7:0]  n_colisoes[4];
`endif

`ifdef AMBIENTE_ESTAT_EN
`define STAT_PORTS(i) .n_passos(n_passos[i]), .n_colisoes(n_colisoes[i]),
`else
`define STAT_PORTS(i)
`endif

`define DUT_PORTS(i) \
    .clock(clock), .reset(reset), .avancar(avancar), .girar(girar), \
    .recolher_entulho(recolher_entulho), .head(head[i]), .left(left[i]), \
    .under(under[i]), .barrier(barrier[i]), .pos_x(pos_x[i]), .pos_y(pos_y[i]), \
    .direcao(direcao[i]), .colisao(colisao[i]), .entulho_removido(entulho_removido[i]), \
    `STAT_PORTS(i) .cmd_invalido(cmd_invalido[i])

    ambiente_robo u_empty (`DUT_PORTS(0));
    ambiente_robo #(.WALL_MAP(64'h100)) u_wall (`DUT_PORTS(1));
    ambiente_robo #(.DEBRIS_MAP(64'h100)) u_debris (`DUT_PORTS(2));
    ambiente_robo #(.START_X(7), .START_Y(7)) u_goal (`DUT_PORTS(3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic a, input logic g, input logic r);
        avancar = a;
        girar = g;
        recolher_entulho = r;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        reset = 1'b1;
    endtask

    initial begin
        do_reset();
        // reset state
        chk("rst_pos_x", pos_x[0], 0);
        chk("rst_pos_y", pos_y[0], 0);
        chk("rst_dir", direcao[0], 0);
        chk("rst_head", head[0], 0);
        chk("rst_left", left[0], 1);
        chk("rst_under", under[0], 0);
        chk("rst_pulses", {colisao[0], entulho_removido[0], cmd_invalido[0]}, 0);
        chk("goal_under", under[3], 1);
        chk("wall_head", head[1], 1);
        chk("debris_barrier", {head[2], barrier[2]}, 2'b01);
`ifdef AMBIENTE_ESTAT_EN
        chk("rst_passos", n_passos[0], 0);
`endif

        // forward three cells, then turn to face the west edge
        step(1, 0, 0);
        chk("fwd1_y", pos_y[0], 1);
        chk("wall_colisao", colisao[1], 1);
        chk("wall_pos", {pos_x[1], pos_y[1]}, 0);
        chk("wall_head_after", head[1], 1);
        step(1, 0, 0);
        chk("fwd2_y", pos_y[0], 2);
        step(1, 0, 0);
        chk("fwd3_y", pos_y[0], 3);
        chk("fwd3_x", pos_x[0], 0);
        step(0, 1, 0);
        chk("turn_dir", direcao[0], 3);
        chk("turn_head", head[0], 1);
        chk("turn_left", left[0], 0);
        chk("turn_pos_y", pos_y[0], 3);
        chk("wall_colisao_end", colisao[1], 0);
`ifdef AMBIENTE_ESTAT_EN
        chk("stat_passos", n_passos[0], 3);
        chk("stat_colisoes", n_colisoes[1], 3);
`endif

        // full collection: four consecutive cycles
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 1);
            chk($sformatf("coll_barrier_%0d", i), barrier[2], 1);
            chk($sformatf("coll_pulse_%0d", i), entulho_removido[2], 0);
        end
        step(0, 0, 1);
        chk("coll_done_pulse", entulho_removido[2], 1);
        chk("coll_done_barrier", barrier[2], 0);
        step(0, 0, 0);
        chk("coll_pulse_off", entulho_removido[2], 0);
        step(1, 0, 0);
        chk("after_coll_pos", {pos_x[2], pos_y[2]}, {3'd0, 3'd1});
        chk("after_coll_colisao", colisao[2], 0);

        // reset restores cleared debris
        do_reset();
        chk("rst_restores_debris", barrier[2], 1);
        chk("rst_restores_pos", {pos_x[2], pos_y[2]}, 0);

        // interrupted collection loses progress
        step(0, 0, 1);
        step(0, 0, 1);
        chk("partial_pulse", entulho_removido[2], 0);
        step(0, 0, 0);
        chk("partial_barrier", barrier[2], 1);
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 1);
            chk($sformatf("retry_pulse_%0d", i), entulho_removido[2], 0);
            chk($sformatf("retry_barrier_%0d", i), barrier[2], 1);
        end
        step(0, 0, 1);
        chk("retry_done_pulse", entulho_removido[2], 1);
        chk("retry_done_barrier", barrier[2], 0);

        // simultaneous commands: girar wins, cmd_invalido pulses
        do_reset();
        step(1, 1, 0);
        chk("multi_dir", direcao[0], 3);
        chk("multi_pos", {pos_x[0], pos_y[0]}, 0);
        chk("multi_pulse", cmd_invalido[0], 1);
        chk("multi_no_colisao", colisao[0], 0);
        step(0, 0, 0);
        chk("multi_pulse_off", cmd_invalido[0], 0);
        chk("multi_hold_dir", direcao[0], 3);

        // recolher beats avancar even with nothing to collect
        step(1, 0, 1);
        chk("multi2_pulse", cmd_invalido[0], 1);
        chk("multi2_pos", {pos_x[0], pos_y[0]}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
